// File: rtl/cache_pkg.sv
// Shared cache definitions: fill FSM states, block geometry and block-base helper.
// Imported by the fill FSM and by the I-/D-cache top levels.
package cache_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } fill_state_t;

   localparam int unsigned BLOCK_BYTES   = 16;
   localparam int unsigned OFFSET_BITS   = 4;
   localparam int unsigned WORD_IDX_BITS = 3;

   // Block-aligned base of a byte address; the in-block offset is discarded.
   function automatic logic [15:0] blockBase(input logic [15:0] addr);
      return {addr[15:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
   endfunction

endpackage

// File: rtl/fill_counter.sv
// 4-bit up counter with synchronous clear and enable, saturating at MAX_COUNT.
// Zero latency to the count output; no backpressure, it simply stops at MAX_COUNT.
module fill_counter #(
   parameter int unsigned MAX_COUNT = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       en,
   output logic [3:0] count
);

   logic atMax;

   assign atMax = (count == 4'(MAX_COUNT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && !atMax) begin
         count <= count + 4'd1;
      end
   end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill: stalls the pipeline, streams BLOCK_WORDS reads, writes each return, then the tag.
// Stall lasts 1 + (memory latency) + BLOCK_WORDS cycles; memory returns are accepted unconditionally.
module cache_fill_fsm
   import cache_pkg::*;
#(
   parameter int unsigned BLOCK_WORDS = 8,
   parameter int unsigned MEM_LATENCY = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     miss_detected,
   input  logic [15:0]              miss_address,
   input  logic                     memory_data_valid,
   output logic                     fsm_busy,
   output logic                     mem_rd_en,
   output logic [15:0]              memory_address,
   output logic                     write_data_array,
   output logic [WORD_IDX_BITS-1:0] fill_word,
   output logic                     write_tag_array
);

   // Counter widths and the word index are sized for an 8-word block.
   if (BLOCK_WORDS != 8 || MEM_LATENCY == 0) begin : gBadParams
      $error("cache_fill_fsm supports BLOCK_WORDS=8 and a nonzero MEM_LATENCY only");
   end

   fill_state_t state;
   fill_state_t nextState;
   logic [15:0] base;
   logic [3:0]  issueCnt;
   logic [3:0]  recvCnt;
   logic        inFill;
   logic        startFill;
   logic        issueEn;
   logic        recvEn;
   logic        lastReturn;

   assign inFill     = (state == FILL);
   assign startFill  = (state == IDLE) && miss_detected;
   assign issueEn    = inFill && (issueCnt < 4'(BLOCK_WORDS));
   assign recvEn     = inFill && memory_data_valid;
   assign lastReturn = recvEn && (recvCnt == 4'(BLOCK_WORDS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      unique case (state)
         IDLE: if (miss_detected) nextState = FILL;
         FILL: if (lastReturn)    nextState = IDLE;
         default:                 nextState = IDLE;
      endcase
   end

   // Base is captured only on entry; miss inputs during a fill are ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base <= '0;
      end else if (startFill) begin
         base <= blockBase(miss_address);
      end
   end

   // Counters are held clear while idle, so each fill starts at word 0.
   fill_counter #(
      .MAX_COUNT (BLOCK_WORDS)
   ) uIssueCnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (!inFill),
      .en    (issueEn),
      .count (issueCnt)
   );

   fill_counter #(
      .MAX_COUNT (BLOCK_WORDS)
   ) uRecvCnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (!inFill),
      .en    (recvEn),
      .count (recvCnt)
   );

   always_comb begin
      fsm_busy         = inFill | startFill;
      mem_rd_en        = issueEn;
      memory_address   = base + {11'b0, issueCnt, 1'b0};
      write_data_array = recvEn;
      fill_word        = recvCnt[WORD_IDX_BITS-1:0];
      write_tag_array  = lastReturn;
   end

endmodule
